// File: rtl/f8_arb_pkg.sv
// Shared types for the f8 RAM arbiter: access-owner encoding and counter width.
package f8_arb_pkg;

    localparam int WAIT_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DMA  = 2'd2
    } owner_t;

endpackage

// File: rtl/f8_arb_wait_ctr.sv
// Saturating starvation counter: counts consecutive cycles a DMA request is denied.
module f8_arb_wait_ctr
    import f8_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic win,
    output logic sat
);

    localparam logic [WAIT_CNT_WIDTH-1:0] MAX_CNT = WAIT_CNT_WIDTH'(MAX_WAIT);

    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req || win) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_CNT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign sat = (wait_cnt_q == MAX_CNT);

endmodule

// File: rtl/f8_mem_arbiter.sv
// Shares the f8 single-port RAM between the core data port (priority) and a
// DMA/debug port that is forced through after MAX_WAIT denied cycles.
module f8_mem_arbiter
    import f8_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  power_on_reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic   sat;
    logic   dma_win;
    owner_t owner_q, owner_d;
    logic   dma_rvalid_q, dma_rvalid_d;

    f8_arb_wait_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_ctr (
        .clk   (clk),
        .rst_n (power_on_reset_n),
        .req   (dma_req),
        .win   (dma_win),
        .sat   (sat)
    );

    // Counter is held at 0 in reset, so the CPU keeps priority there too.
    assign dma_win   = dma_req && (!cpu_req || sat);
    assign cpu_stall = cpu_req && dma_win;
    assign dma_gnt   = dma_win;

    assign mem_en = cpu_req || dma_req;

    always_comb begin
        if (dma_win) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_comb begin
        owner_d = OWNER_NONE;
        if (dma_win) begin
            owner_d = OWNER_DMA;
        end else if (cpu_req) begin
            owner_d = OWNER_CPU;
        end
        dma_rvalid_d = (owner_d == OWNER_DMA) && !dma_we;
    end

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            owner_q      <= OWNER_NONE;
            dma_rvalid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    // Both ports see the RAM output; each side qualifies it on its own.
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign dma_rvalid = dma_rvalid_q;

    a_rvalid_owner: assert property (@(posedge clk) disable iff (!power_on_reset_n)
        dma_rvalid_q |-> (owner_q == OWNER_DMA));

endmodule

// File: tb/tb_f8_mem_arbiter.sv
// Directed bench for f8_mem_arbiter: MAX_WAIT=4 instance with a RAM model,
// plus a MAX_WAIT=1 instance sharing the same request inputs.
module tb_f8_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;

    logic          cpu_stall, dma_gnt, dma_rvalid, mem_en, mem_we;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    logic          cpu_stall_1, dma_gnt_1, dma_rvalid_1, mem_en_1, mem_we_1;
    logic [DW-1:0] cpu_rdata_1, dma_rdata_1, mem_wdata_1;
    logic [AW-1:0] mem_addr_1;
    logic [DW-1:0] mem_rdata_1 = '0;

    logic [DW-1:0] ram [0:65535];

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    f8_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) u_dut (
        .clk(clk), .power_on_reset_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    f8_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(1)) u_dut1 (
        .clk(clk), .power_on_reset_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall_1), .cpu_rdata(cpu_rdata_1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt_1), .dma_rdata(dma_rdata_1), .dma_rvalid(dma_rvalid_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1)
    );

    // Synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // A pending DMA request must not drop before it has been granted.
    logic pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= 1'b0;
        else        pend <= dma_req && !dma_gnt;
    end
    always @(posedge clk) begin
        if (rst_n && pend && !dma_req) begin
            $display("FAIL dma_req_drop: dma_req=%b while ungranted, required 1", dma_req);
            nfail++;
        end
    end

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        ntests++;
        if ({cpu_stall, dma_gnt, dma_rvalid, mem_en, mem_we} !== 5'b00000) begin
            $display("FAIL reset_flags: got %b required 00000",
                     {cpu_stall, dma_gnt, dma_rvalid, mem_en, mem_we});
            nfail++;
        end
        ntests++;
        if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00 || cpu_rdata !== 8'h00 || dma_rdata !== 8'h00) begin
            $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h required all 0",
                     mem_addr, mem_wdata, cpu_rdata, dma_rdata);
            nfail++;
        end
        cpu_req = 1'b1; cpu_addr = 16'h0042; dma_req = 1'b1; dma_addr = 16'h0200; #1;
        ntests++;
        if ({cpu_stall, dma_gnt, mem_en} !== 3'b001 || mem_addr !== 16'h0042) begin
            $display("FAIL reset_cpu_prio: stall/gnt/en=%b addr=%h required 001 0042",
                     {cpu_stall, dma_gnt, mem_en}, mem_addr);
            nfail++;
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A; #1;
        ntests++;
        if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 8'h5A) begin
            $display("FAIL cpu_write: stall=%b we=%b addr=%h wdata=%h required 0 1 0010 5a",
                     cpu_stall, mem_we, mem_addr, mem_wdata);
            nfail++;
        end
        @(negedge clk);
        cpu_we = 1'b0; #1;
        ntests++;
        if (cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
            $display("FAIL cpu_read_issue: stall=%b en=%b we=%b required 0 1 0",
                     cpu_stall, mem_en, mem_we);
            nfail++;
        end
        @(posedge clk); #1;
        ntests++;
        if (cpu_rdata !== 8'h5A || dma_rvalid !== 1'b0) begin
            $display("FAIL cpu_rdata: rdata=%h rvalid=%b required 5a 0", cpu_rdata, dma_rvalid);
            nfail++;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_dma();
        @(negedge clk);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'hA5; #1;
        ntests++;
        if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 8'hA5) begin
            $display("FAIL dma_write: gnt=%b we=%b addr=%h wdata=%h required 1 1 0200 a5",
                     dma_gnt, mem_we, mem_addr, mem_wdata);
            nfail++;
        end
        @(posedge clk); #1;
        ntests++;
        if (dma_rvalid !== 1'b0) begin
            $display("FAIL dma_write_rvalid: got %b required 0", dma_rvalid);
            nfail++;
        end
        @(negedge clk);
        dma_we = 1'b0; #1;
        ntests++;
        if (dma_gnt !== 1'b1 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
            $display("FAIL dma_read_issue: gnt=%b we=%b stall=%b required 1 0 0",
                     dma_gnt, mem_we, cpu_stall);
            nfail++;
        end
        @(posedge clk); #1;
        ntests++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 8'hA5) begin
            $display("FAIL dma_read_data: rvalid=%b rdata=%h required 1 a5", dma_rvalid, dma_rdata);
            nfail++;
        end
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        ntests++;
        if (dma_rvalid !== 1'b0) begin
            $display("FAIL dma_rvalid_clear: got %b required 0", dma_rvalid);
            nfail++;
        end
    endtask

    task automatic test_starvation();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200; #1;
            ntests++;
            if (dma_gnt !== logic'(c == 5) || cpu_stall !== logic'(c == 5) ||
                mem_addr !== ((c == 5) ? 16'h0200 : 16'h0010)) begin
                $display("FAIL starve_cycle%0d: gnt=%b stall=%b addr=%h required %b %b %h", c,
                         dma_gnt, cpu_stall, mem_addr, logic'(c == 5), logic'(c == 5),
                         (c == 5) ? 16'h0200 : 16'h0010);
                nfail++;
            end
        end
        @(posedge clk); #1;
        ntests++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 8'hA5) begin
            $display("FAIL starve_rdata: rvalid=%b rdata=%h required 1 a5", dma_rvalid, dma_rdata);
            nfail++;
        end
        @(negedge clk);
        dma_req = 1'b0; #1;
        ntests++;
        if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0 || mem_addr !== 16'h0010) begin
            $display("FAIL starve_cpu_next: stall=%b gnt=%b addr=%h required 0 0 0010",
                     cpu_stall, dma_gnt, mem_addr);
            nfail++;
        end
        @(posedge clk); #1;
        ntests++;
        if (cpu_rdata !== 8'h5A || dma_rvalid !== 1'b0) begin
            $display("FAIL starve_cpu_rdata: rdata=%h rvalid=%b required 5a 0", cpu_rdata, dma_rvalid);
            nfail++;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200; #1;
        ntests++;
        if (dma_gnt !== 1'b1) begin
            $display("FAIL rmr_grant: gnt=%b required 1", dma_gnt);
            nfail++;
        end
        @(posedge clk); #1;
        ntests++;
        if (dma_rvalid !== 1'b1) begin
            $display("FAIL rmr_pre_rvalid: got %b required 1", dma_rvalid);
            nfail++;
        end
        rst_n = 1'b0; #1;
        ntests++;
        if (dma_rvalid !== 1'b0) begin
            $display("FAIL rmr_async_clear: got %b required 0", dma_rvalid);
            nfail++;
        end
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; #1;
        ntests++;
        if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            $display("FAIL rmr_reset_prio: gnt=%b stall=%b required 0 0", dma_gnt, cpu_stall);
            nfail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            ntests++;
            if (dma_gnt !== logic'(c == 5) || cpu_stall !== logic'(c == 5)) begin
                $display("FAIL rmr_wait_cycle%0d: gnt=%b stall=%b required %b %b", c,
                         dma_gnt, cpu_stall, logic'(c == 5), logic'(c == 5));
                nfail++;
            end
            @(posedge clk); #1;
            ntests++;
            if (dma_rvalid !== logic'(c == 5)) begin
                $display("FAIL rmr_rvalid_cycle%0d: got %b required %b", c, dma_rvalid, logic'(c == 5));
                nfail++;
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_back_to_back();
        int wi;
        wi = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b1;
            cpu_addr = 16'(16'h0100 + wi); cpu_wdata = 8'(8'h30 + wi);
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 8'hD0; #1;
            ntests++;
            if (dma_gnt !== logic'(c % 5 == 0) || cpu_stall !== logic'(c % 5 == 0)) begin
                $display("FAIL b2b_cycle%0d: gnt=%b stall=%b required %b %b", c,
                         dma_gnt, cpu_stall, logic'(c % 5 == 0), logic'(c % 5 == 0));
                nfail++;
            end
            if (!cpu_stall) wi++;
        end
        ntests++;
        if (wi != 16) begin
            $display("FAIL b2b_cpu_count: accepted %0d required 16", wi);
            nfail++;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle();
            cpu_req = 1'b1; cpu_addr = 16'(16'h0100 + i);
            @(posedge clk); #1;
            ntests++;
            if (cpu_rdata !== 8'(8'h30 + i)) begin
                $display("FAIL b2b_readback%0d: got %h required %h", i, cpu_rdata, 8'(8'h30 + i));
                nfail++;
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_max_wait1();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200; #1;
            ntests++;
            if (dma_gnt_1 !== logic'(c % 2 == 0) || cpu_stall_1 !== logic'(c % 2 == 0) ||
                mem_addr_1 !== ((c % 2 == 0) ? 16'h0200 : 16'h0010)) begin
                $display("FAIL mw1_cycle%0d: gnt=%b stall=%b addr=%h required %b %b %h", c,
                         dma_gnt_1, cpu_stall_1, mem_addr_1, logic'(c % 2 == 0),
                         logic'(c % 2 == 0), (c % 2 == 0) ? 16'h0200 : 16'h0010);
                nfail++;
            end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_cpu_read();
        test_dma();
        test_starvation();
        test_reset_mid_read();
        test_back_to_back();
        test_max_wait1();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
